// File: rtl/active_video_gate_if.sv
// Video-side signal bundle for active_video_gate: sync/pixel inputs and gated RGB, DE, coordinates.
// master drives the sync and RGB inputs; slave is the gate itself.
interface active_video_gate_if;
  logic       pixel_en;
  logic       hsync;
  logic       vsync;
  logic       is_field_odd;
  logic       red_in;
  logic       green_in;
  logic       blue_in;
  logic       red_out;
  logic       green_out;
  logic       blue_out;
  logic       de;
  logic [9:0] x;
  logic [8:0] y;
  logic       field_odd;
  logic       sync_lost;

  modport master (
    output pixel_en, hsync, vsync, is_field_odd, red_in, green_in, blue_in,
    input  red_out, green_out, blue_out, de, x, y, field_odd, sync_lost
  );

  modport slave (
    input  pixel_en, hsync, vsync, is_field_odd, red_in, green_in, blue_in,
    output red_out, green_out, blue_out, de, x, y, field_odd, sync_lost
  );
endinterface

// File: rtl/active_video_gate.sv
// Finds the active picture from hsync/vsync and pixel_en, blanks RGB outside it, emits DE and x/y.
// Outputs are registered one clk after the input sample; no backpressure, the pixel stream is free-running.
module active_video_gate #(
  parameter int H_START   = 128,
  parameter int H_ACTIVE  = 768,
  parameter int V_START   = 23,
  parameter int V_ACTIVE  = 288,
  parameter int H_TIMEOUT = 1020
) (
  input logic                 clk,
  input logic                 reset,
  active_video_gate_if.slave  vid
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PORCH  = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;
  localparam logic [1:0] BLANK  = 2'd3;

  localparam logic [10:0] H_FIRST = 11'(H_START - 1);
  localparam logic [10:0] H_LOST  = 11'(H_TIMEOUT);
  localparam logic [9:0]  X_LAST  = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LO    = 10'(V_START);
  localparam logic [9:0]  V_HI    = 10'(V_START + V_ACTIVE);
  localparam logic [8:0]  Y_OFF   = 9'(V_START);

  logic [1:0]  state;
  logic        hsync_d;
  logic        vsync_d;
  logic        hs_edge;
  logic        vs_edge;
  logic [10:0] h_count;
  logic [8:0]  v_count;
  logic [8:0]  v_count_next;
  logic        line_active;
  logic        in_active;

  // Edge history tracks the inputs even through reset so a level held across reset is not seen as an edge.
  always_ff @(posedge clk) begin
    hsync_d <= vid.hsync;
    vsync_d <= vid.vsync;
  end

  always_comb begin
    hs_edge      = vid.hsync & ~hsync_d;
    vs_edge      = vid.vsync & ~vsync_d;
    in_active    = (state == ACTIVE);
    v_count_next = v_count;
    if (vs_edge) begin
      v_count_next = '0;
    end else if (hs_edge && (v_count != 9'h1FF)) begin
      v_count_next = v_count + 9'd1;
    end
    line_active = ({1'b0, v_count_next} >= V_LO) && ({1'b0, v_count_next} < V_HI);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      h_count       <= '0;
      v_count       <= '0;
      vid.x         <= '0;
      vid.y         <= '0;
      vid.field_odd <= 1'b0;
      vid.sync_lost <= 1'b1;
      vid.de        <= 1'b0;
      vid.red_out   <= 1'b0;
      vid.green_out <= 1'b0;
      vid.blue_out  <= 1'b0;
    end else begin
      v_count <= v_count_next;
      if (vs_edge) begin
        vid.field_odd <= vid.is_field_odd;
      end

      if (hs_edge) begin
        h_count <= '0;
      end else if (vid.pixel_en && (h_count != 11'h7FF)) begin
        h_count <= h_count + 11'd1;
      end

      vid.de        <= in_active;
      vid.red_out   <= in_active & vid.red_in;
      vid.green_out <= in_active & vid.green_in;
      vid.blue_out  <= in_active & vid.blue_in;

      // A new hsync always restarts the line, including a short line cut off mid-ACTIVE.
      if (hs_edge) begin
        state         <= line_active ? PORCH : BLANK;
        vid.sync_lost <= 1'b0;
      end else if (vid.pixel_en && (state != IDLE) && (h_count == H_LOST)) begin
        state         <= IDLE;
        vid.sync_lost <= 1'b1;
      end else if (vid.pixel_en) begin
        case (state)
          PORCH: begin
            if (h_count == H_FIRST) begin
              state <= ACTIVE;
              vid.x <= '0;
              vid.y <= v_count - Y_OFF;
            end
          end
          ACTIVE: begin
            if (vid.x == X_LAST) begin
              state <= BLANK;
            end else begin
              vid.x <= vid.x + 10'd1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
